// File: rtl/key_matrix_scan_pkg.sv
// key_matrix_scan_pkg
// Shared constants, the key-event record carried through the event queue,
// and a lowest-set-bit helper used to pick the next pending key.
// Optional feature macro: KEY_MATRIX_SCAN_RELEASE_EVENT_EN adds a release
// flag to each queued event.
package key_matrix_scan_pkg;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int KEY_CODE_W = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_KEYS   = ROWS * COLS;

  typedef struct packed {
    logic [KEY_CODE_W-1:0] code;
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
    logic                  rel;
`endif
  } key_event_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = KEY_CODE_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_matrix_scan_if.sv
// key_matrix_scan_if
// Key-event handshake between the scanner (master) and its consumer (slave).
//   key_valid : head event present
//   key_ready : consumer takes the head when key_valid && key_ready
//   key_code  : key index of the head event (0 when idle)
//   key_rel   : head event is a release (0 when idle or feature absent)
interface key_matrix_scan_if;
  import key_matrix_scan_pkg::*;

  logic                  key_valid;
  logic                  key_ready;
  logic [KEY_CODE_W-1:0] key_code;
  logic                  key_rel;

  modport master (output key_valid, key_code, key_rel, input key_ready);
  modport slave  (input key_valid, key_code, key_rel, output key_ready);

endinterface

// File: rtl/key_event_fifo.sv
// key_event_fifo
// Shift-register queue of key events. Entry 0 is always the head, so the
// outputs come straight from flops. Vacated slots are refilled with zero,
// which keeps data_o at 0 whenever the queue is empty.
// A push and a pop in the same cycle both succeed, even when full.
// A push into a full queue without a pop is silently dropped; the caller
// detects that case from full_o.
// Ports:
//   clk, rst  : clock, async active-low reset
//   push_i    : write data_i this cycle
//   data_i    : event to write
//   pop_i     : consumer accepts head (ignored when empty)
//   data_o    : head event
//   full_o    : all slots occupied
//   empty_o   : no slot occupied
module key_event_fifo
  import key_matrix_scan_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  key_event_t data_i,
  input  logic       pop_i,
  output key_event_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  key_event_t       mem_q [DEPTH];
  key_event_t       mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic             pop;
  logic             placed;

  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    placed = 1'b0;
    pop    = pop_i & vld_q[0];
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      mem_d[DEPTH-1] = '0;
      vld_d[DEPTH-1] = 1'b0;
    end
    // Write into the first free slot after the pop has been applied.
    if (push_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!placed && !vld_d[i]) begin
          mem_d[i] = data_i;
          vld_d[i] = 1'b1;
          placed   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign data_o  = mem_q[0];
  assign full_o  = vld_q[DEPTH-1];
  assign empty_o = ~vld_q[0];

endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan
// 4x4 key matrix scanner: drives one row low at a time, samples the synced
// columns at the end of each row step, debounces every key independently
// and queues press events (and optionally release events) for a consumer.
// Optional feature macro: KEY_MATRIX_SCAN_RELEASE_EVENT_EN (release events).
// Ports:
//   clk, rst  : system clock, async active-low reset
//   KEY_COL   : column sense, active-low, asynchronous
//   KEY_ROW   : row drive, active-low, one-hot-low
//   key_down  : debounced key state, bit = row*4+col
//   overflow  : sticky, an event was dropped on a full queue
//   evt       : key-event handshake (master side)
module key_matrix_scan
  import key_matrix_scan_pkg::*;
#(
  parameter int SCAN_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COLS-1:0]     KEY_COL,
  output logic [ROWS-1:0]     KEY_ROW,
  output logic [NUM_KEYS-1:0] key_down,
  output logic                overflow,
  key_matrix_scan_if.master   evt
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [COLS-1:0]     col_s1_q, col_s2_q;
  logic [CNT_W-1:0]    step_q, step_d;
  logic [1:0]          row_q, row_d;
  logic                wrap;
  logic [3:0]          db_cnt_q [NUM_KEYS];
  logic [3:0]          db_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] down_q, down_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
  logic [NUM_KEYS-1:0] rel_pend_q, rel_pend_d;
`endif
  logic                push_q, push_d;
  key_event_t          push_ev_q, push_ev_d;
  key_event_t          head;
  logic                fifo_full, fifo_empty;
  logic                overflow_q, overflow_d;

  assign wrap = (step_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    step_d = wrap ? '0 : step_q + 1'b1;
    row_d  = wrap ? row_q + 2'd1 : row_q;
  end

  assign KEY_ROW = ~(4'b0001 << row_q);

  always_comb begin
    down_d    = down_q;
    press_d   = press_q;
    push_d    = 1'b0;
    push_ev_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) db_cnt_d[k] = db_cnt_q[k];
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
    rel_pend_d = rel_pend_q;
`endif

    // One pending event per cycle: presses before releases, lowest key first.
    // Selection clears before the debounce loop so a fresh set always wins.
    if (|press_q) begin
      push_d                 = 1'b1;
      push_ev_d.code         = lowest_set(press_q);
      press_d[push_ev_d.code] = 1'b0;
    end
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
    else if (|rel_pend_q) begin
      push_d                    = 1'b1;
      push_ev_d.code            = lowest_set(rel_pend_q);
      push_ev_d.rel             = 1'b1;
      rel_pend_d[push_ev_d.code] = 1'b0;
    end
`endif

    for (int k = 0; k < NUM_KEYS; k++) begin
      if (db_cnt_q[k] == 4'(DEBOUNCE_SAMPLES)) begin
        down_d[k]   = ~down_q[k];
        db_cnt_d[k] = '0;
        if (!down_q[k]) press_d[k] = 1'b1;
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
        else rel_pend_d[k] = 1'b1;
`endif
      end else if (wrap && row_q == 2'(k / COLS)) begin
        // Raw press is a low column; count only while it disagrees with key_down.
        if (!col_s2_q[k % COLS] != down_q[k]) db_cnt_d[k] = db_cnt_q[k] + 4'd1;
        else                                  db_cnt_d[k] = '0;
      end
    end
  end

  // A push into a full queue survives only if the head is taken the same cycle.
  assign overflow_d = overflow_q | (push_q & fifo_full & ~evt.key_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_s1_q   <= '0;
      col_s2_q   <= '0;
      step_q     <= '0;
      row_q      <= '0;
      down_q     <= '0;
      press_q    <= '0;
      push_q     <= 1'b0;
      push_ev_q  <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= '0;
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
      rel_pend_q <= '0;
`endif
    end else begin
      col_s1_q   <= KEY_COL;
      col_s2_q   <= col_s1_q;
      step_q     <= step_d;
      row_q      <= row_d;
      down_q     <= down_d;
      press_q    <= press_d;
      push_q     <= push_d;
      push_ev_q  <= push_ev_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < NUM_KEYS; k++) db_cnt_q[k] <= db_cnt_d[k];
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
      rel_pend_q <= rel_pend_d;
`endif
    end
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .data_i  (push_ev_q),
    .pop_i   (evt.key_ready),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt.key_valid = ~fifo_empty;
  assign evt.key_code  = head.code;
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
  assign evt.key_rel   = head.rel;
`else
  assign evt.key_rel   = 1'b0;
`endif
  assign key_down = down_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
module tb_key_matrix_scan;
  import key_matrix_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  KEY_COL;
  logic [3:0]  KEY_ROW;
  logic [15:0] key_down;
  logic        overflow;
  logic [15:0] pressed = '0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [4:0] ev_q[$];
  int         ev_t[$];

  key_matrix_scan_if evt();

  key_matrix_scan #(.SCAN_DIV(4), .DEBOUNCE_SAMPLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .KEY_COL  (KEY_COL),
    .KEY_ROW  (KEY_ROW),
    .key_down (key_down),
    .overflow (overflow),
    .evt      (evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Matrix model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    KEY_COL = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !KEY_ROW[r]) KEY_COL[c] = 1'b0;
  end

  // Event log: handshakes seen 1ns after each falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst && evt.key_valid && evt.key_ready) begin
      ev_q.push_back({evt.key_code, evt.key_rel});
      ev_t.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ev_at(input int i);
    if (i < ev_q.size()) return {1'b0, ev_q[i]};
    return 6'h20;
  endfunction

  function automatic int ev_t_at(input int i);
    if (i < ev_t.size()) return ev_t[i];
    return -1000;
  endfunction

  // Leaves the bench on the falling edge at which reset is released;
  // "edge k" below is the k-th rising edge after that point.
  task automatic do_reset(input logic [15:0] keys);
    rst           = 1'b0;
    evt.key_ready = 1'b0;
    pressed       = keys;
    repeat (3) @(negedge clk);
    ev_q.delete();
    ev_t.delete();
    rst = 1'b1;
  endtask

  logic [3:0] exp_row;
  logic       any_valid;

  initial begin
    evt.key_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_row",   KEY_ROW, 4'hE);
    chk("rst_down",  key_down, 16'h0);
    chk("rst_valid", evt.key_valid, 1'b0);
    chk("rst_code",  evt.key_code, 4'h0);
    chk("rst_rel",   evt.key_rel, 1'b0);
    chk("rst_ovf",   overflow, 1'b0);
    rst = 1'b1;

    // Row sequence, 4 cycles per row
    for (int i = 0; i < 20; i++) begin
      exp_row = ~(4'b0001 << ((i / 4) % 4));
      chk("row_seq", KEY_ROW, exp_row);
      @(negedge clk);
    end

    // Key 6 held: row-1 samples on edges 8,24,40,56 -> key_down at 57
    do_reset(16'h0040);
    repeat (56) @(negedge clk);
    chk("kd6_before", key_down, 16'h0000);
    @(negedge clk);
    chk("kd6_rise", key_down, 16'h0040);
    @(negedge clk);
    chk("kd6_valid_early", evt.key_valid, 1'b0);
    @(negedge clk);
    chk("kd6_valid", evt.key_valid, 1'b1);
    chk("kd6_code",  evt.key_code, 4'd6);
    chk("kd6_rel",   evt.key_rel, 1'b0);
    repeat (3) @(negedge clk);
    chk("kd6_hold_valid", evt.key_valid, 1'b1);
    chk("kd6_hold_code",  evt.key_code, 4'd6);
    evt.key_ready = 1'b1;
    @(negedge clk);
    chk("kd6_popped",    evt.key_valid, 1'b0);
    chk("kd6_idle_code", evt.key_code, 4'd0);
    chk("kd6_nevents",   ev_q.size(), 1);
    evt.key_ready = 1'b0;

    // Key 6 bouncing every frame: never debounces
    do_reset(16'h0000);
    any_valid = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (i % 16 == 0) pressed = ((i / 16) % 2 == 0) ? 16'h0040 : 16'h0000;
      @(negedge clk);
      any_valid = any_valid | evt.key_valid;
    end
    chk("bounce_down",  key_down, 16'h0000);
    chk("bounce_valid", any_valid, 1'b0);

    // Keys 9, 2, 15 with consumer ready
    do_reset(16'h8204);
    evt.key_ready = 1'b1;
    repeat (80) @(negedge clk);
    chk("k3_down",    key_down, 16'h8204);
    chk("k3_nevents", ev_q.size(), 3);
    chk("k3_ev0",     ev_at(0), {1'b0, 4'd2, 1'b0});
    chk("k3_ev1",     ev_at(1), {1'b0, 4'd9, 1'b0});
    chk("k3_ev2",     ev_at(2), {1'b0, 4'd15, 1'b0});

    // Same-row keys 4,5,7 debounce together: ascending, back-to-back
    do_reset(16'h00B0);
    evt.key_ready = 1'b1;
    repeat (70) @(negedge clk);
    chk("row1_nevents", ev_q.size(), 3);
    chk("row1_ev0",     ev_at(0), {1'b0, 4'd4, 1'b0});
    chk("row1_ev1",     ev_at(1), {1'b0, 4'd5, 1'b0});
    chk("row1_ev2",     ev_at(2), {1'b0, 4'd7, 1'b0});
    chk("row1_gap0",    ev_t_at(1) - ev_t_at(0), 1);
    chk("row1_gap1",    ev_t_at(2) - ev_t_at(1), 1);

    // Six keys, consumer stalled: 1,3,12,13 kept, 14,15 dropped
    do_reset(16'hF00A);
    repeat (72) @(negedge clk);
    chk("ovf_set",   overflow, 1'b1);
    chk("ovf_valid", evt.key_valid, 1'b1);
    chk("ovf_head",  evt.key_code, 4'd1);
    chk("ovf_down",  key_down, 16'hF00A);
    evt.key_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("ovf_nevents", ev_q.size(), 4);
    chk("ovf_ev0",     ev_at(0), {1'b0, 4'd1, 1'b0});
    chk("ovf_ev1",     ev_at(1), {1'b0, 4'd3, 1'b0});
    chk("ovf_ev2",     ev_at(2), {1'b0, 4'd12, 1'b0});
    chk("ovf_ev3",     ev_at(3), {1'b0, 4'd13, 1'b0});
    chk("ovf_drained", evt.key_valid, 1'b0);
    chk("ovf_sticky",  overflow, 1'b1);

    // Asynchronous reset between clock edges clears everything
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ovf",   overflow, 1'b0);
    chk("arst_down",  key_down, 16'h0000);
    chk("arst_row",   KEY_ROW, 4'hE);
    chk("arst_valid", evt.key_valid, 1'b0);

    // Press then release key 0
    do_reset(16'h0001);
    evt.key_ready = 1'b1;
    repeat (70) @(negedge clk);
    chk("k0_down", key_down, 16'h0001);
    pressed = 16'h0000;
    repeat (80) @(negedge clk);
    chk("k0_released", key_down, 16'h0000);
    chk("k0_ev0",      ev_at(0), {1'b0, 4'd0, 1'b0});
`ifdef KEY_MATRIX_SCAN_RELEASE_EVENT_EN
    chk("k0_nevents", ev_q.size(), 2);
    chk("k0_ev1",     ev_at(1), {1'b0, 4'd0, 1'b1});
`else
    chk("k0_nevents", ev_q.size(), 1);
`endif
    chk("k0_ovf", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
